// File: rtl/demux_32bit_4canales_pkg.sv
// ---------------------------------------------------------------------------
// demux_32bit_4canales_pkg
// Shared definitions for the 4-channel word demultiplexer:
//   DEFAULT_WIDTH : default data word width in bits
//   NUM_CH        : number of output channels (the design is fixed at 4)
//   CNT_WIDTH     : width of the accepted-word counter
//   ch_sel_t      : 2-bit channel index used for in_sel and rr_ptr
// ---------------------------------------------------------------------------
package demux_32bit_4canales_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int NUM_CH        = 4;
    localparam int CNT_WIDTH     = 16;

    // A 2-bit index covers exactly the four channels, so incrementing it
    // wraps 3 -> 0 on its own.
    typedef logic [1:0] ch_sel_t;

endpackage : demux_32bit_4canales_pkg

// File: rtl/demux_32bit_4canales_canal.sv
// ---------------------------------------------------------------------------
// canal_salida
// One output channel: a single-entry holding register with a valid flag.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   load        : write load_data into the register this edge
//   load_data   : word to store
//   out_ready   : consumer takes the held word this cycle
//   out_valid   : register holds a word
//   out_data    : held word (kept stable until a new load)
// ---------------------------------------------------------------------------
module canal_salida
    import demux_32bit_4canales_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // A load wins over a drain so that a simultaneous drain+load keeps the
    // channel full with the new word and no bubble appears. After a plain
    // drain the data register keeps its old contents; only valid clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : canal_salida

// File: rtl/demux_32bit_4canales.sv
// ---------------------------------------------------------------------------
// demux_32bit_4canales
// Routes each accepted input word to one of four single-entry output
// channels, chosen either by in_sel or by an internal round-robin pointer.
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   in_data               : input word
//   in_sel                : destination channel when auto_mode = 0
//   auto_mode             : 1 = round-robin destination, in_sel ignored
//   out_valid[3:0]        : per-channel "holds a word" flags
//   out_ready[3:0]        : per-channel consumer take signals
//   out_data0..out_data3  : held words of channels 0..3
//   rr_ptr                : next round-robin destination
//   xfer_count            : number of accepted input words (wraps)
// ---------------------------------------------------------------------------
module demux_32bit_4canales
    import demux_32bit_4canales_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = NUM_CH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  ch_sel_t              in_sel,
    input  logic                 auto_mode,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output ch_sel_t              rr_ptr,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    ch_sel_t          target;
    logic             xfer;
    logic [3:0]       load;
    logic [WIDTH-1:0] data_q [4];

    // The destination follows auto_mode in the same cycle it changes; the
    // pointer itself is never touched by a mode switch.
    always_comb begin
        target   = auto_mode ? rr_ptr : in_sel;
        in_ready = ~out_valid[target] | out_ready[target];
        xfer     = in_valid & in_ready;
        load     = '0;
        load[target] = xfer;
    end

    // Only the target channel can be loaded; every channel drains on its own.
    for (genvar i = 0; i < NCH; i++) begin : g_canal
        canal_salida #(
            .WIDTH(WIDTH)
        ) u_canal (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .load_data(in_data),
            .out_ready(out_ready[i]),
            .out_valid(out_valid[i]),
            .out_data (data_q[i])
        );
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

    // The round-robin pointer advances only on auto-mode transfers, so a
    // stalled channel holds the pointer instead of being skipped. The word
    // counter counts every transfer and wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + 1'b1;
            if (auto_mode) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

endmodule : demux_32bit_4canales

// File: doc/demux_32bit_4canales.md
DEMUX_32BIT_4CANALES -- requirements
Module: demux_32bit_4canales

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NCH, default 4, number of output channels; only 4 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 in_data  input  WIDTH  input word.
REQ-008 in_sel  input  2  destination channel when auto_mode=0 (00->ch0, 01->ch1, 10->ch2, 11->ch3).
REQ-009 auto_mode  input  1  1 = round-robin destination; in_sel ignored.
REQ-010 out_valid  output  4  bit i: channel i holds a word.
REQ-011 out_ready  input  4  bit i: consumer i takes the word this cycle.
REQ-012 out_data0..out_data3  output  WIDTH each  held word of channel 0..3.
REQ-013 rr_ptr  output  2  next round-robin destination.
REQ-014 xfer_count  output  16  total accepted input words.

Function
REQ-015 Target channel t SHALL be rr_ptr when auto_mode=1, else in_sel.
REQ-016 in_ready SHALL be combinational: ~out_valid[t] | out_ready[t].
REQ-017 Input transfer SHALL occur when in_valid & in_ready; next edge loads in_data into channel t and sets out_valid[t]=1.
REQ-018 Latency: accepted word SHALL appear on out_data<t> with out_valid[t]=1 exactly one cycle after transfer.
REQ-019 Channel i drain SHALL occur when out_valid[i] & out_ready[i]; without simultaneous load, out_valid[i] clears next edge.
REQ-020 Simultaneous drain and load on same channel SHALL leave out_valid=1 with the new word (full throughput, no bubble).
REQ-021 Non-target channels SHALL hold data and valid unchanged except for their own drains.
REQ-022 out_data<i> SHALL remain stable while out_valid[i]=1 and out_ready[i]=0.
REQ-023 in_valid without transfer (target full, not draining) SHALL change no state; in_data/in_sel need not be held but only accepted values matter.
REQ-024 rr_ptr SHALL increment modulo 4 (3->0) on each transfer with auto_mode=1; unchanged otherwise.
REQ-025 Switching auto_mode SHALL take effect same cycle; rr_ptr keeps its value across mode changes.
REQ-026 xfer_count SHALL increment by 1 per transfer, wrapping 0xFFFF->0x0000.
REQ-027 Out_valid bits SHALL be independent: any combination of channels may be full at once.

Reset
REQ-028 reset=1 SHALL immediately force out_valid=0000, out_data0..3=0, rr_ptr=0, xfer_count=0.
REQ-029 Reset mid-operation SHALL discard all held words; no transfer is recognised while reset=1.
REQ-030 After reset release, in_ready SHALL be 1 (all channels empty).

Structure
REQ-031 Shared package SHALL hold WIDTH default, NCH, the 2-bit channel-select type, and the 16-bit counter width.
REQ-032 One sub-module, canal_salida, SHALL implement a single channel's one-entry register (load, drain, valid); instantiated 4 times.
REQ-033 Top level SHALL contain target selection, in_ready logic, rr_ptr and xfer_count.

Verification
REQ-034 auto_mode=0, in_sel=10, in_data=0xCAFEF00D, out_ready=0000 -> next cycle out_valid=0100, out_data2=0xCAFEF00D, xfer_count=1.
REQ-035 Channel 2 full, out_ready[2]=0, in_sel=10, in_valid=1 -> in_ready=0, data unchanged; raise out_ready[2] -> in_ready=1, new word replaces old, out_valid[2] stays 1.
REQ-036 auto_mode=1, out_ready=1111, words 1,2,3,4,5 back-to-back -> ch0=1, ch1=2, ch2=3, ch3=4, ch0=5; rr_ptr 0,1,2,3,0,1; one word per cycle.
REQ-037 xfer_count preloaded via 65535 transfers -> next transfer gives 0x0000.
REQ-038 Channels 0 and 3 full, reset pulsed asynchronously mid-cycle -> out_valid=0000, out_data all 0, rr_ptr=0 before next edge; in_ready=1.
REQ-039 auto_mode=1, ch1 full with rr_ptr=1, out_ready=0000 -> in_ready=0, rr_ptr stays 1 (no skip to ch2).
